fp_sum_win_avg: RTL and testbench
=================================

# fp_sum_win_avg

Windowed averaging stage directly downstream of the fixed-point adder `sumFp`. Consumes the adder's full-resolution sum S(17,14) as a valid-qualified stream, accumulates N = 2^LOG2_N consecutive samples without loss, and emits one averaged, rounded and saturated S(9,7) result per window. It is the rate-reducing quantization point between the adder and the narrow output path.

## Interface
- NB_IN, 17, input word width (adder full-resolution output)
- NBF_IN, 14, input fractional bits
- LOG2_N, 3, log2 of window length (N = 8)
- NB_OUT, 9, output word width
- NBF_OUT, 7, output fractional bits
- clk  input  1  single clock, rising-edge
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  i_data carries a sample this cycle
- i_data  input  NB_IN  signed sample S(NB_IN,NBF_IN)
- i_clear  input  1  synchronous discard of the partial window
- o_data  output  NB_OUT  signed average S(NB_OUT,NBF_OUT)
- o_valid  output  1  one-cycle pulse, o_data/o_sat valid
- o_sat  output  1  o_data was saturated (qualified by o_valid)
- o_fill  output  LOG2_N  samples accepted in current window

## Operation
- Accumulator width NB_ACC = NB_IN + LOG2_N (20); never overflows for a full window.
- FSM states: FILL (accumulating), EMIT (quantizing held window). Reset state FILL.
- FILL: each cycle with i_valid=1, acc += sign-extended i_data, o_fill increments.
- Sample that brings count to N (o_fill = N-1 and i_valid=1): acc + i_data loaded into hold register, acc and o_fill cleared to 0, FSM -> EMIT.
- EMIT (exactly one cycle): hold register quantized and registered onto o_data/o_sat, o_valid=1; FSM -> FILL. Samples with i_valid=1 during EMIT are accepted into the new window (no stall, no backpressure).
- Quantization: shift SH = LOG2_N + NBF_IN - NBF_OUT (10) with arithmetic right shift; result then saturated to [-2^(NB_OUT-1), 2^(NB_OUT-1)-1] = [-256, 255]; o_sat=1 when clamped.
- i_clear=1: acc and o_fill cleared; any i_valid sample in the same cycle is discarded (clear wins), including a would-be window-completing sample (no EMIT follows). i_clear does not cancel an EMIT already in progress.
- i_valid=0 cycles hold acc and o_fill unchanged.

## Timing
- Reset (i_rst_n=0, asynchronous): o_data=0, o_valid=0, o_sat=0, o_fill=0, acc=0, hold=0, FSM=FILL. Reset mid-window discards the partial sum; reset during EMIT suppresses the pulse.
- Latency: o_valid rises one clock after the edge that accepts the N-th sample of a window.
- o_data and o_sat hold their last value between pulses; only o_valid returns to 0.
- Max throughput: one sample per clock; back-to-back windows give an o_valid pulse every N cycles.
- o_fill updates on the same edge that accepts a sample.

## Configuration
- FP_SUM_WIN_AVG_ROUND_EN defined: round-half-up before the shift (add 2^(SH-1), then shift); the addition is done at NB_ACC+1 bits so it cannot wrap.
- Not defined: plain truncation (floor) by arithmetic shift; no rounding adder.
- Saturation, timing and handshake are identical in both builds.

## Test plan
- Reset then 8 consecutive samples of 16384 (1.0) -> one cycle after the 8th, o_valid=1, o_data=128, o_sat=0; o_fill reads 0..7 then 0.
- 8 samples of 65535 -> o_data=255, o_sat=1; 8 samples of -65536 -> o_data=-256, o_sat=1.
- Seven zeros plus one 512 (sum 512, 0.5 LSB) -> o_data=1 with ROUND_EN, 0 without; sum -512 -> 0 with ROUND_EN, -1 without.
- 16 back-to-back samples of 8192 with i_valid held high -> two o_valid pulses 8 cycles apart, both o_data=64; sample during EMIT counted in second window.
- 5 samples of 16384, i_clear, then 8 samples of -16384 -> single pulse o_data=-128; i_clear coincident with the 8th sample -> no pulse, o_fill=0.
- Assert i_rst_n=0 after 6 samples and between the 8th-sample edge and EMIT -> all outputs 0 immediately, no o_valid pulse, next window starts from o_fill=0.

Source files
------------

// File: rtl/fp_sum_win_avg.sv
// Windowed averager behind the sumFp adder: sums 2^LOG2_N samples at full
// precision, then quantizes the window sum to S(NB_OUT,NBF_OUT) with saturation.
// Build option: FP_SUM_WIN_AVG_ROUND_EN selects round-half-up; otherwise floor.
//
// state   | meaning
// FILL    | accumulating samples of the current window
// EMIT    | quantizing the held window sum onto the outputs (one cycle)
module fp_sum_win_avg #(
    parameter int NB_IN   = 17,
    parameter int NBF_IN  = 14,
    parameter int LOG2_N  = 3,
    parameter int NB_OUT  = 9,
    parameter int NBF_OUT = 7
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [NB_IN-1:0]  i_data,
    input  logic              i_clear,
    output logic [NB_OUT-1:0] o_data,
    output logic              o_valid,
    output logic              o_sat,
    output logic [LOG2_N-1:0] o_fill
);

    localparam int NB_ACC = NB_IN + LOG2_N;
    localparam int NB_Q   = NB_ACC + 1;
    localparam int SH     = LOG2_N + NBF_IN - NBF_OUT;

    // Window length is a power of two, so the last fill index is all ones.
    localparam logic [LOG2_N-1:0] FILL_LAST = '1;

    localparam logic signed [NB_Q-1:0] MAX_Q = {{(NB_Q-NB_OUT+1){1'b0}}, {(NB_OUT-1){1'b1}}};
    localparam logic signed [NB_Q-1:0] MIN_Q = {{(NB_Q-NB_OUT+1){1'b1}}, {(NB_OUT-1){1'b0}}};

`ifdef FP_SUM_WIN_AVG_ROUND_EN
    localparam logic [NB_Q-1:0] RND = {{(NB_Q-SH){1'b0}}, 1'b1, {(SH-1){1'b0}}};
`endif

    typedef enum logic {
        ST_FILL,
        ST_EMIT
    } state_t;

    state_t state, state_nxt;

    logic signed [NB_ACC-1:0] acc;
    logic signed [NB_ACC-1:0] hold;
    logic signed [NB_ACC-1:0] sample_ext;
    logic signed [NB_ACC-1:0] acc_sum;
    logic                     win_done;

    logic signed [NB_Q-1:0]   q_in;
    logic signed [NB_Q-1:0]   q_shift;
    logic [NB_OUT-1:0]        q_data;
    logic                     q_sat;

    assign sample_ext = {{LOG2_N{i_data[NB_IN-1]}}, i_data};
    assign acc_sum    = acc + sample_ext;
    // Clear wins over a sample, so a clearing cycle never completes a window.
    assign win_done   = i_valid && !i_clear && (o_fill == FILL_LAST);

    // State register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: EMIT always lasts exactly one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL: if (win_done) state_nxt = ST_EMIT;
            ST_EMIT: state_nxt = ST_FILL;
            default: state_nxt = ST_FILL;
        endcase
    end

    // Quantize the held sum: optional half-LSB bias, arithmetic shift, clamp.
    always_comb begin
        q_data = '0;
        q_sat  = 1'b0;
`ifdef FP_SUM_WIN_AVG_ROUND_EN
        q_in   = {hold[NB_ACC-1], hold} + RND;
`else
        q_in   = {hold[NB_ACC-1], hold};
`endif
        q_shift = q_in >>> SH;
        if (q_shift > MAX_Q) begin
            q_data = MAX_Q[NB_OUT-1:0];
            q_sat  = 1'b1;
        end else if (q_shift < MIN_Q) begin
            q_data = MIN_Q[NB_OUT-1:0];
            q_sat  = 1'b1;
        end else begin
            q_data = q_shift[NB_OUT-1:0];
        end
    end

    // Accumulator, fill counter and output registers; samples are taken in
    // both states so the stream never stalls.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc     <= '0;
            hold    <= '0;
            o_fill  <= '0;
            o_data  <= '0;
            o_sat   <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            if (i_clear) begin
                acc    <= '0;
                o_fill <= '0;
            end else if (i_valid) begin
                if (o_fill == FILL_LAST) begin
                    hold   <= acc_sum;
                    acc    <= '0;
                    o_fill <= '0;
                end else begin
                    acc    <= acc_sum;
                    o_fill <= o_fill + LOG2_N'(1);
                end
            end
            o_valid <= (state == ST_EMIT);
            if (state == ST_EMIT) begin
                o_data <= q_data;
                o_sat  <= q_sat;
            end
        end
    end

endmodule

// File: tb/tb_fp_sum_win_avg.sv
// Self-checking bench for fp_sum_win_avg: directed scenarios plus a randomized
// stream compared against a window-sum / divide / clamp reference model.
module tb_fp_sum_win_avg;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [16:0] i_data;
    logic        i_clear;
    logic [8:0]  o_data;
    logic        o_valid;
    logic        o_sat;
    logic [2:0]  o_fill;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_sum_win_avg dut (
        .clk     (clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_clear (i_clear),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_sat   (o_sat),
        .o_fill  (o_fill)
    );

    // Reference: average = sum / 8 in units of 2^-7, i.e. sum / 1024, floor
    // or round-half-up, then clamp to the 9-bit signed range.
    function automatic void exp_avg(input longint sum, output logic signed [8:0] q, output logic sat);
        longint s;
        longint f;
        s = sum;
`ifdef FP_SUM_WIN_AVG_ROUND_EN
        s = s + 512;
`endif
        f = s / 1024;
        if ((s % 1024) != 0 && s < 0) f = f - 1;
        if (f > 255) begin
            q = 9'sd255; sat = 1'b1;
        end else if (f < -256) begin
            q = -9'sd256; sat = 1'b1;
        end else begin
            q = 9'(f); sat = 1'b0;
        end
    endfunction

    // Apply one cycle of inputs, then settle just after the active edge.
    task automatic drive(input logic v, input logic [16:0] d, input logic c);
        i_valid = v;
        i_data  = d;
        i_clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0; i_valid = 1'b0; i_clear = 1'b0; i_data = '0;
        #3;
        checks++; if (o_data !== 9'd0)  begin errors++; $display("FAIL reset_o_data got %0h exp 0", o_data); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %b exp 0", o_valid); end
        checks++; if (o_sat !== 1'b0)   begin errors++; $display("FAIL reset_o_sat got %b exp 0", o_sat); end
        checks++; if (o_fill !== 3'd0)  begin errors++; $display("FAIL reset_o_fill got %0d exp 0", o_fill); end
        @(posedge clk); #1;
        i_rst_n = 1'b1;
    endtask

    task automatic test_unity;
        for (int i = 0; i < 8; i++) begin
            checks++; if (o_fill !== 3'(i)) begin errors++; $display("FAIL unity_fill got %0d exp %0d", o_fill, i); end
            drive(1'b1, 17'd16384, 1'b0);
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL unity_early_valid got %b exp 0 at %0d", o_valid, i); end
        end
        checks++; if (o_fill !== 3'd0) begin errors++; $display("FAIL unity_fill_wrap got %0d exp 0", o_fill); end
        drive(1'b0, 17'd0, 1'b0);
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL unity_valid got %b exp 1", o_valid); end
        checks++; if (o_data !== 9'd128) begin errors++; $display("FAIL unity_data got %0d exp 128", $signed(o_data)); end
        checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL unity_sat got %b exp 0", o_sat); end
        drive(1'b0, 17'd0, 1'b0);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL unity_pulse_len got %b exp 0", o_valid); end
        checks++; if (o_data !== 9'd128) begin errors++; $display("FAIL unity_hold got %0d exp 128", $signed(o_data)); end
    endtask

    task automatic test_saturation;
        logic [16:0]       pat [2];
        logic signed [8:0] exq [2];
        pat[0] = 17'h0FFFF; exq[0] = 9'sd255;
        pat[1] = 17'h10000; exq[1] = -9'sd256;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 8; i++) drive(1'b1, pat[p], 1'b0);
            drive(1'b0, 17'd0, 1'b0);
            checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL sat_valid[%0d] got %b exp 1", p, o_valid); end
            checks++; if (o_data !== exq[p]) begin errors++; $display("FAIL sat_data[%0d] got %0d exp %0d", p, $signed(o_data), exq[p]); end
            checks++; if (o_sat !== 1'b1) begin errors++; $display("FAIL sat_flag[%0d] got %b exp 1", p, o_sat); end
        end
    endtask

    task automatic test_rounding;
        logic [16:0]       last [2];
        logic signed [8:0] exq  [2];
        last[0] = 17'd512;
        last[1] = 17'h1FE00;
`ifdef FP_SUM_WIN_AVG_ROUND_EN
        exq[0] = 9'sd1; exq[1] = 9'sd0;
`else
        exq[0] = 9'sd0; exq[1] = -9'sd1;
`endif
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 7; i++) drive(1'b1, 17'd0, 1'b0);
            drive(1'b1, last[p], 1'b0);
            drive(1'b0, 17'd0, 1'b0);
            checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL round_valid[%0d] got %b exp 1", p, o_valid); end
            checks++; if (o_data !== exq[p]) begin errors++; $display("FAIL round_data[%0d] got %0d exp %0d", p, $signed(o_data), exq[p]); end
            checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL round_sat[%0d] got %b exp 0", p, o_sat); end
        end
    endtask

    task automatic test_back_to_back;
        int npulse = 0;
        int first  = -1;
        int second = -1;
        for (int s = 0; s < 18; s++) begin
            drive(s < 16, 17'd8192, 1'b0);
            if (s == 8) begin
                checks++; if (o_fill !== 3'd1) begin errors++; $display("FAIL b2b_emit_sample got fill %0d exp 1", o_fill); end
            end
            if (o_valid === 1'b1) begin
                npulse++;
                if (first < 0) first = s; else second = s;
                checks++; if (o_data !== 9'd64) begin errors++; $display("FAIL b2b_data got %0d exp 64", $signed(o_data)); end
            end
        end
        checks++; if (npulse != 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", npulse); end
        checks++; if (first != 8) begin errors++; $display("FAIL b2b_first got %0d exp 8", first); end
        checks++; if (second - first != 8) begin errors++; $display("FAIL b2b_spacing got %0d exp 8", second - first); end
    endtask

    task automatic test_clear;
        int npulse = 0;
        for (int i = 0; i < 5; i++) drive(1'b1, 17'd16384, 1'b0);
        drive(1'b0, 17'd0, 1'b1);
        checks++; if (o_fill !== 3'd0) begin errors++; $display("FAIL clear_fill got %0d exp 0", o_fill); end
        for (int s = 0; s < 10; s++) begin
            drive(s < 8, 17'h1C000, 1'b0);
            if (o_valid === 1'b1) begin
                npulse++;
                checks++; if (o_data !== 9'h180) begin errors++; $display("FAIL clear_data got %0d exp -128", $signed(o_data)); end
            end
        end
        checks++; if (npulse != 1) begin errors++; $display("FAIL clear_pulses got %0d exp 1", npulse); end
        for (int i = 0; i < 7; i++) drive(1'b1, 17'd16384, 1'b0);
        drive(1'b1, 17'd16384, 1'b1);
        checks++; if (o_fill !== 3'd0) begin errors++; $display("FAIL clear_last_fill got %0d exp 0", o_fill); end
        for (int s = 0; s < 3; s++) begin
            drive(1'b0, 17'd0, 1'b0);
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL clear_last_pulse got %b exp 0", o_valid); end
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 6; i++) drive(1'b1, 17'd16384, 1'b0);
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_fill !== 3'd0) begin errors++; $display("FAIL rstmid_fill got %0d exp 0", o_fill); end
        #2 i_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) drive(1'b1, 17'd16384, 1'b0);
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        checks++; if (o_data !== 9'd0) begin errors++; $display("FAIL rstemit_data got %0d exp 0", $signed(o_data)); end
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rstemit_valid got %b exp 0", o_valid); end
        checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL rstemit_sat got %b exp 0", o_sat); end
        checks++; if (o_fill !== 3'd0) begin errors++; $display("FAIL rstemit_fill got %0d exp 0", o_fill); end
        #2 i_rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            drive(1'b0, 17'd0, 1'b0);
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rstemit_pulse got %b exp 0", o_valid); end
        end
        drive(1'b1, 17'd16384, 1'b0);
        checks++; if (o_fill !== 3'd1) begin errors++; $display("FAIL rstmid_restart got %0d exp 1", o_fill); end
        for (int i = 0; i < 7; i++) drive(1'b1, 17'd16384, 1'b0);
        drive(1'b0, 17'd0, 1'b0);
        checks++; if (o_valid !== 1'b1 || o_data !== 9'd128) begin
            errors++; $display("FAIL rstmid_window got valid %b data %0d exp 1/128", o_valid, $signed(o_data));
        end
    endtask

    task automatic test_random;
        int                count = 0;
        longint            sum   = 0;
        bit                pend  = 1'b0;
        bit                have_last = 1'b0;
        logic signed [8:0] pend_q = '0;
        logic              pend_sat = 1'b0;
        logic signed [8:0] last_q = '0;
        logic              last_sat = 1'b0;
        logic              v, c;
        logic [16:0]       d;
        drive(1'b0, 17'd0, 1'b1);
        drive(1'b0, 17'd0, 1'b0);
        for (int n = 0; n < 600; n++) begin
            v = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 5))
                0:       d = 17'h0FFFF;
                1:       d = 17'h10000;
                default: d = 17'($urandom);
            endcase
            drive(v, d, c);
            checks++; if (o_valid !== pend) begin errors++; $display("FAIL rand_valid n=%0d got %b exp %b", n, o_valid, pend); end
            if (pend) begin
                checks++; if (o_data !== pend_q) begin errors++; $display("FAIL rand_data n=%0d got %0d exp %0d", n, $signed(o_data), pend_q); end
                checks++; if (o_sat !== pend_sat) begin errors++; $display("FAIL rand_sat n=%0d got %b exp %b", n, o_sat, pend_sat); end
                have_last = 1'b1; last_q = pend_q; last_sat = pend_sat;
            end else if (have_last) begin
                checks++; if (o_data !== last_q || o_sat !== last_sat) begin
                    errors++; $display("FAIL rand_hold n=%0d got %0d/%b exp %0d/%b", n, $signed(o_data), o_sat, last_q, last_sat);
                end
            end
            pend = 1'b0;
            if (c) begin
                count = 0; sum = 0;
            end else if (v) begin
                sum = sum + longint'($signed(d));
                count++;
                if (count == 8) begin
                    exp_avg(sum, pend_q, pend_sat);
                    pend = 1'b1; count = 0; sum = 0;
                end
            end
            checks++; if (o_fill !== 3'(count)) begin errors++; $display("FAIL rand_fill n=%0d got %0d exp %0d", n, o_fill, count); end
        end
    endtask

    initial begin
        test_reset;
        test_unity;
        test_saturation;
        test_rounding;
        test_back_to_back;
        test_clear;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
